alu4_arbiter: RTL and testbench
===============================

ALU4_ARBITER -- requirements
Module: alu4_arbiter

Interface
REQ-001 The block SHALL have parameter DW, default 4, operand/result width in bits.
REQ-002 The block SHALL have these ports (name  direction  width  meaning):
  clk  in  1  single clock; all state updates on rising edge
  rst  in  1  reset, synchronous, active-high
  req0_valid  in  1  requester 0 has an operation
  req0_ready  out  1  requester 0 operation accepted this cycle
  req0_op  in  3  requester 0 opcode
  req0_a, req0_b  in  DW  requester 0 operands
  req1_valid, req1_ready, req1_op, req1_a, req1_b  same as requester 0, for requester 1
  res_valid  out  1  result register holds an unconsumed result
  res_ready  in  1  consumer accepts result
  res_data  out  DW  result value
  res_carry  out  1  carry/borrow/shifted-out bit
  res_tag  out  1  requester index that issued the result
  op_count  out  8  count of accepted operations

Function
REQ-003 Opcodes SHALL be 000 ADD, 001 SUB (a-b), 010 AND, 011 OR, 100 XOR, 101 NOT a, 110 SHL a by 1, 111 SHR a by 1.
REQ-004 ADD SHALL set res_carry to bit DW of a+b; SUB SHALL set res_carry to 1 when a<b (borrow); SHL/SHR SHALL set res_carry to the bit shifted out; logic ops SHALL set res_carry to 0.
REQ-005 Arithmetic SHALL be unsigned modulo 2^DW; res_data SHALL be the low DW bits.
REQ-006 A one-entry result register SHALL exist; it is free when res_valid=0 or (res_valid=1 and res_ready=1) in the same cycle.
REQ-007 Exactly one requester SHALL be granted per cycle, and only when the result register is free; granted reqN_ready=1 combinationally, the other 0.
REQ-008 Arbitration SHALL be round-robin: if both valid, grant the requester not granted last; if one valid, grant it; the last-grant pointer SHALL update only on an accepted transfer.
REQ-009 An operation accepted in cycle N SHALL appear on res_valid/res_data/res_carry/res_tag in cycle N+1 (latency 1).
REQ-010 res_* outputs SHALL hold stable while res_valid=1 and res_ready=0.
REQ-011 Drain and accept in the same cycle SHALL be allowed, giving full throughput of one operation per cycle.
REQ-012 The FSM SHALL have states EMPTY (res_valid=0) and FULL (res_valid=1): EMPTY->FULL on accept; FULL->EMPTY on drain without accept; FULL->FULL on drain with accept or on stall.
REQ-013 op_count SHALL increment by 1 per accepted operation and wrap 255->0.
REQ-014 Requesters SHALL keep op/a/b stable while valid and not ready; the block does not check this.

Reset
REQ-015 When rst=1 at a clock edge: state EMPTY, res_valid=0, res_data=0, res_carry=0, res_tag=0, op_count=0, last-grant pointer=1 (so requester 0 wins first contention).
REQ-016 During rst=1 reqN_ready SHALL be 0; a pending result SHALL be discarded on reset mid-operation.

Configuration
REQ-017 With macro ALU4_ARB_FLAGS_EN defined, extra output res_zero (1 bit, registered with the result, 1 when res_data==0) SHALL exist and reset to 0.
REQ-018 Without ALU4_ARB_FLAGS_EN, res_zero SHALL not exist and no zero-detect logic is built.

Structure
REQ-019 A shared package alu4_pkg SHALL hold the opcode enum typedef and the constants OP_ADD..OP_SHR.
REQ-020 The opcode datapath SHALL be a combinational sub-module alu4_core (inputs op, a, b; outputs data, carry), instanced once after the grant mux.

Verification
REQ-021 Reset then req0 ADD a=9 b=8 -> next cycle res_valid=1, res_data=1, res_carry=1, res_tag=0, op_count=1.
REQ-022 Both valid every cycle, res_ready=1 -> tags alternate 0,1,0,1 with one result per cycle.
REQ-023 SUB a=3 b=5 with res_ready=0 for 3 cycles -> res_data=14, res_carry=1 held stable, both reqN_ready=0 until drain.
REQ-024 255 accepted operations then one more -> op_count wraps to 0.
REQ-025 rst asserted while res_valid=1 -> next cycle res_valid=0, op_count=0; first contention grants requester 0.
REQ-026 With ALU4_ARB_FLAGS_EN, XOR a=5 b=5 -> res_data=0, res_zero=1, res_carry=0.

Source files
------------

// File: rtl/alu4_pkg.sv
// Shared definitions for the two-requester ALU arbiter: opcode encoding,
// result-register FSM states and small width constants.
package alu4_pkg;

    // Opcode encoding shared by requesters, the arbiter and the ALU core.
    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_NOT = 3'b101,
        OP_SHL = 3'b110,
        OP_SHR = 3'b111
    } alu_op_e;

    // Occupancy of the one-entry result register.
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } res_state_e;

    localparam int OP_W    = 3;
    localparam int COUNT_W = 8;

    // Requester index used when nobody has been granted yet, chosen so that
    // requester 0 wins the first contention after reset.
    localparam logic LAST_GRANT_RST = 1'b1;

endpackage : alu4_pkg

// File: rtl/alu4_core.sv
// Combinational ALU datapath: one operation per call, result plus a single
// carry/borrow/shifted-out flag. Arithmetic is unsigned modulo 2^DW.
module alu4_core
    import alu4_pkg::*;
#(
    parameter int DW = 4
) (
    input  logic [OP_W-1:0] op,
    input  logic [DW-1:0]   a,
    input  logic [DW-1:0]   b,
    output logic [DW-1:0]   data,
    output logic            carry
);

    logic [DW:0] sum_s;
    logic [DW:0] diff_s;

    // Extended-width sum and difference; the top bit is carry-out / borrow.
    always_comb begin
        sum_s  = {1'b0, a} + {1'b0, b};
        diff_s = {1'b0, a} - {1'b0, b};
    end

    // Opcode decode: select the result and its flag bit.
    always_comb begin
        data  = {DW{1'b0}};
        carry = 1'b0;
        case (alu_op_e'(op))
            OP_ADD: begin
                data  = sum_s[DW-1:0];
                carry = sum_s[DW];
            end
            OP_SUB: begin
                data  = diff_s[DW-1:0];
                carry = diff_s[DW];
            end
            OP_AND: begin
                data  = a & b;
                carry = 1'b0;
            end
            OP_OR: begin
                data  = a | b;
                carry = 1'b0;
            end
            OP_XOR: begin
                data  = a ^ b;
                carry = 1'b0;
            end
            OP_NOT: begin
                data  = ~a;
                carry = 1'b0;
            end
            OP_SHL: begin
                data  = {a[DW-2:0], 1'b0};
                carry = a[DW-1];
            end
            OP_SHR: begin
                data  = {1'b0, a[DW-1:1]};
                carry = a[0];
            end
            default: begin
                data  = {DW{1'b0}};
                carry = 1'b0;
            end
        endcase
    end

endmodule : alu4_core

// File: rtl/alu4_arbiter.sv
// Two-requester round-robin arbiter in front of a shared ALU with a one-entry
// registered result buffer (latency 1, full throughput with drain+accept).
// Optional feature: define ALU4_ARB_FLAGS_EN to add the registered res_zero
// output (1 when the stored result is zero).
module alu4_arbiter
    import alu4_pkg::*;
#(
    parameter int DW = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req0_valid,
    output logic               req0_ready,
    input  logic [2:0]         req0_op,
    input  logic [DW-1:0]      req0_a,
    input  logic [DW-1:0]      req0_b,
    input  logic               req1_valid,
    output logic               req1_ready,
    input  logic [2:0]         req1_op,
    input  logic [DW-1:0]      req1_a,
    input  logic [DW-1:0]      req1_b,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [DW-1:0]      res_data,
    output logic               res_carry,
    output logic               res_tag,
`ifdef ALU4_ARB_FLAGS_EN
    output logic               res_zero,
`endif
    output logic [COUNT_W-1:0] op_count
);

    res_state_e         state_q, state_d;
    logic               last_q, last_d;
    logic [DW-1:0]      data_q, data_d;
    logic               carry_q, carry_d;
    logic               tag_q, tag_d;
    logic [COUNT_W-1:0] count_q, count_d;

    logic               free_s;
    logic               grant0_s;
    logic               grant1_s;
    logic               accept_s;
    logic               sel_s;
    logic [OP_W-1:0]    mux_op_s;
    logic [DW-1:0]      mux_a_s;
    logic [DW-1:0]      mux_b_s;
    logic [DW-1:0]      core_data_s;
    logic               core_carry_s;

    // The result slot can take a new operation when empty or draining now.
    always_comb begin
        if (state_q == ST_EMPTY) begin
            free_s = 1'b1;
        end else begin
            free_s = res_ready;
        end
    end

    // Round-robin grant: contention goes to the requester not granted last;
    // nothing is granted while in reset or while the slot is blocked.
    always_comb begin
        grant0_s = 1'b0;
        grant1_s = 1'b0;
        if (rst || !free_s) begin
            grant0_s = 1'b0;
            grant1_s = 1'b0;
        end else if (req0_valid && req1_valid) begin
            if (last_q) begin
                grant0_s = 1'b1;
            end else begin
                grant1_s = 1'b1;
            end
        end else if (req0_valid) begin
            grant0_s = 1'b1;
        end else if (req1_valid) begin
            grant1_s = 1'b1;
        end else begin
            grant0_s = 1'b0;
            grant1_s = 1'b0;
        end
    end

    assign accept_s   = grant0_s | grant1_s;
    assign sel_s      = grant1_s;
    assign req0_ready = grant0_s;
    assign req1_ready = grant1_s;

    // Operand mux feeding the single shared ALU core.
    always_comb begin
        if (sel_s) begin
            mux_op_s = req1_op;
            mux_a_s  = req1_a;
            mux_b_s  = req1_b;
        end else begin
            mux_op_s = req0_op;
            mux_a_s  = req0_a;
            mux_b_s  = req0_b;
        end
    end

    alu4_core #(
        .DW    (DW)
    ) u_core (
        .op    (mux_op_s),
        .a     (mux_a_s),
        .b     (mux_b_s),
        .data  (core_data_s),
        .carry (core_carry_s)
    );

    // Result-slot FSM next state: fill on accept, empty on drain without refill.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: begin
                if (accept_s) begin
                    state_d = ST_FULL;
                end else begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (res_ready && !accept_s) begin
                    state_d = ST_EMPTY;
                end else begin
                    state_d = ST_FULL;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase
    end

    // Result payload, grant pointer and counter load only on an accepted
    // operation, so the outputs stay frozen during a consumer stall.
    always_comb begin
        data_d  = data_q;
        carry_d = carry_q;
        tag_d   = tag_q;
        last_d  = last_q;
        count_d = count_q;
        if (accept_s) begin
            data_d  = core_data_s;
            carry_d = core_carry_s;
            tag_d   = sel_s;
            last_d  = sel_s;
            count_d = count_q + 8'd1;
        end else begin
            data_d  = data_q;
            carry_d = carry_q;
            tag_d   = tag_q;
            last_d  = last_q;
            count_d = count_q;
        end
    end

    // State and result registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            last_q  <= LAST_GRANT_RST;
            data_q  <= {DW{1'b0}};
            carry_q <= 1'b0;
            tag_q   <= 1'b0;
            count_q <= 8'd0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            data_q  <= data_d;
            carry_q <= carry_d;
            tag_q   <= tag_d;
            count_q <= count_d;
        end
    end

`ifdef ALU4_ARB_FLAGS_EN
    logic zero_q, zero_d;

    // Zero flag is captured alongside the result it describes.
    always_comb begin
        if (accept_s) begin
            zero_d = (core_data_s == {DW{1'b0}});
        end else begin
            zero_d = zero_q;
        end
    end

    // Zero flag register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            zero_q <= 1'b0;
        end else begin
            zero_q <= zero_d;
        end
    end

    assign res_zero = zero_q;
`endif

    assign res_valid = (state_q == ST_FULL);
    assign res_data  = data_q;
    assign res_carry = carry_q;
    assign res_tag   = tag_q;
    assign op_count  = count_q;

endmodule : alu4_arbiter

// File: tb/tb_alu4_arbiter.sv
// Self-checking bench for alu4_arbiter (DW=4): a behavioural model checked on
// every falling edge, plus directed scenarios with hand-computed literals.
module tb_alu4_arbiter;

    localparam int DW   = 4;
    localparam int MASK = 15;

    logic          clk;
    logic          rst;
    logic          req0_valid, req1_valid;
    logic          req0_ready, req1_ready;
    logic [2:0]    req0_op, req1_op;
    logic [DW-1:0] req0_a, req0_b, req1_a, req1_b;
    logic          res_valid, res_ready;
    logic [DW-1:0] res_data;
    logic          res_carry, res_tag;
    logic [7:0]    op_count;
`ifdef ALU4_ARB_FLAGS_EN
    logic          res_zero;
`endif

    int n_cmp;
    int n_bad;
    bit model_on;

    // Model state: what the result register and counter must hold.
    int m_valid, m_data, m_carry, m_tag, m_count, m_last;

    alu4_arbiter #(.DW(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_op    (req0_op),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_op    (req1_op),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_carry  (res_carry),
        .res_tag    (res_tag),
`ifdef ALU4_ARB_FLAGS_EN
        .res_zero   (res_zero),
`endif
        .op_count   (op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Operation semantics written from the opcode table with integer arithmetic.
    function automatic void model_alu(input int op, input int a, input int b,
                                      output int d, output int c);
        case (op)
            0: begin d = (a + b) & MASK; c = ((a + b) > MASK) ? 1 : 0; end
            1: begin d = (a - b) & MASK; c = (a < b) ? 1 : 0; end
            2: begin d = a & b;          c = 0; end
            3: begin d = a | b;          c = 0; end
            4: begin d = a ^ b;          c = 0; end
            5: begin d = (~a) & MASK;    c = 0; end
            6: begin d = (a * 2) & MASK; c = ((a * 2) > MASK) ? 1 : 0; end
            default: begin d = a / 2;    c = a % 2; end
        endcase
    endfunction

    // Compare process: check DUT against the model, then advance the model
    // with the inputs that will be sampled at the next rising edge.
    always @(negedge clk) begin
        int g, d, c;
        bit free;
        if (model_on) begin
            free = (m_valid == 0) || res_ready;
            g = -1;
            if (!rst && free) begin
                if (req0_valid && req1_valid) g = (m_last == 0) ? 1 : 0;
                else if (req0_valid)          g = 0;
                else if (req1_valid)          g = 1;
            end
            check("m_ready0", {31'd0, req0_ready}, (g == 0) ? 32'd1 : 32'd0);
            check("m_ready1", {31'd0, req1_ready}, (g == 1) ? 32'd1 : 32'd0);
            check("m_res_valid", {31'd0, res_valid}, m_valid);
            check("m_op_count", {24'd0, op_count}, m_count);
            if (m_valid != 0) begin
                check("m_res_data", {28'd0, res_data}, m_data);
                check("m_res_carry", {31'd0, res_carry}, m_carry);
                check("m_res_tag", {31'd0, res_tag}, m_tag);
`ifdef ALU4_ARB_FLAGS_EN
                check("m_res_zero", {31'd0, res_zero}, (m_data == 0) ? 32'd1 : 32'd0);
`endif
            end
            if (rst) begin
                m_valid = 0; m_data = 0; m_carry = 0; m_tag = 0;
                m_count = 0; m_last = 1;
            end else if (g >= 0) begin
                if (g == 0) model_alu(int'(req0_op), int'(req0_a), int'(req0_b), d, c);
                else        model_alu(int'(req1_op), int'(req1_a), int'(req1_b), d, c);
                m_valid = 1; m_data = d; m_carry = c; m_tag = g;
                m_count = (m_count + 1) % 256; m_last = g;
            end else if (m_valid != 0 && res_ready) begin
                m_valid = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int n, input logic v, input logic [2:0] op,
                           input logic [3:0] a, input logic [3:0] b);
        if (n == 0) begin
            req0_valid = v; req0_op = op; req0_a = a; req0_b = b;
        end else begin
            req1_valid = v; req1_op = op; req1_a = a; req1_b = b;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        n_cmp = 0; n_bad = 0; model_on = 1'b0;
        m_valid = 0; m_data = 0; m_carry = 0; m_tag = 0; m_count = 0; m_last = 1;
        rst = 1'b1; res_ready = 1'b0;
        set_req(0, 1'b1, 3'd0, 4'd1, 4'd1);
        set_req(1, 1'b1, 3'd0, 4'd2, 4'd2);
        tick();
        model_on = 1'b1;
        tick();

        // Reset state, with both requesters asking: nobody may be granted.
        @(negedge clk);
        check("rst_ready0", {31'd0, req0_ready}, 32'd0);
        check("rst_ready1", {31'd0, req1_ready}, 32'd0);
        check("rst_res_valid", {31'd0, res_valid}, 32'd0);
        check("rst_res_data", {28'd0, res_data}, 32'd0);
        check("rst_op_count", {24'd0, op_count}, 32'd0);
        set_req(1, 1'b0, 3'd0, 4'd0, 4'd0);
        rst = 1'b0;

        // First transaction: ADD 9+8 -> 1 with carry, tag 0, count 1.
        set_req(0, 1'b1, 3'd0, 4'd9, 4'd8);
        res_ready = 1'b1;
        tick();
        set_req(0, 1'b0, 3'd0, 4'd0, 4'd0);
        @(negedge clk);
        check("add_valid", {31'd0, res_valid}, 32'd1);
        check("add_data", {28'd0, res_data}, 32'd1);
        check("add_carry", {31'd0, res_carry}, 32'd1);
        check("add_tag", {31'd0, res_tag}, 32'd0);
        check("add_count", {24'd0, op_count}, 32'd1);
        tick();

        // Back-to-back contention after reset: tags 0,1,0,1,... every cycle.
        do_reset();
        res_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            set_req(0, 1'b1, 3'(i), 4'(i + 3), 4'(i * 2));
            set_req(1, 1'b1, 3'(7 - i), 4'(15 - i), 4'(i + 1));
            tick();
            @(negedge clk);
            check("rr_valid", {31'd0, res_valid}, 32'd1);
            check("rr_tag", {31'd0, res_tag}, 32'(i % 2));
        end
        set_req(0, 1'b0, 3'd0, 4'd0, 4'd0);
        set_req(1, 1'b0, 3'd0, 4'd0, 4'd0);
        tick();

        // Stall: SUB 3-5 -> 14 with borrow, held while res_ready=0.
        res_ready = 1'b0;
        set_req(0, 1'b1, 3'd1, 4'd3, 4'd5);
        tick();
        set_req(0, 1'b1, 3'd2, 4'd6, 4'd7);
        set_req(1, 1'b1, 3'd3, 4'd1, 4'd8);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_data", {28'd0, res_data}, 32'd14);
            check("stall_carry", {31'd0, res_carry}, 32'd1);
            check("stall_ready0", {31'd0, req0_ready}, 32'd0);
            check("stall_ready1", {31'd0, req1_ready}, 32'd0);
            tick();
        end
        res_ready = 1'b1;
        @(negedge clk);
        check("drain_ready1", {31'd0, req1_ready}, 32'd1);
        tick();
        set_req(0, 1'b0, 3'd0, 4'd0, 4'd0);
        set_req(1, 1'b0, 3'd0, 4'd0, 4'd0);
        @(negedge clk);
        check("drain_data", {28'd0, res_data}, 32'd9);
        check("drain_tag", {31'd0, res_tag}, 32'd1);

        // Reset while a result is pending: it is discarded, requester 0 wins next.
        res_ready = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_valid", {31'd0, res_valid}, 32'd0);
        check("mid_rst_count", {24'd0, op_count}, 32'd0);
        set_req(0, 1'b1, 3'd5, 4'd5, 4'd0);
        set_req(1, 1'b1, 3'd6, 4'd9, 4'd0);
        #1;
        check("post_rst_ready0", {31'd0, req0_ready}, 32'd1);
        check("post_rst_ready1", {31'd0, req1_ready}, 32'd0);
        res_ready = 1'b1;
        tick();
        set_req(0, 1'b0, 3'd0, 4'd0, 4'd0);
        @(negedge clk);
        check("not_data", {28'd0, res_data}, 32'd10);
        check("not_tag", {31'd0, res_tag}, 32'd0);
        tick();
        set_req(1, 1'b0, 3'd0, 4'd0, 4'd0);
        @(negedge clk);
        check("shl_data", {28'd0, res_data}, 32'd2);
        check("shl_carry", {31'd0, res_carry}, 32'd1);
        set_req(0, 1'b1, 3'd7, 4'd9, 4'd0);
        tick();
        set_req(0, 1'b0, 3'd0, 4'd0, 4'd0);
        @(negedge clk);
        check("shr_data", {28'd0, res_data}, 32'd4);
        check("shr_carry", {31'd0, res_carry}, 32'd1);
        tick();

`ifdef ALU4_ARB_FLAGS_EN
        // Zero flag: XOR 5^5 -> 0.
        set_req(0, 1'b1, 3'd4, 4'd5, 4'd5);
        tick();
        set_req(0, 1'b0, 3'd0, 4'd0, 4'd0);
        @(negedge clk);
        check("xor_data", {28'd0, res_data}, 32'd0);
        check("xor_zero", {31'd0, res_zero}, 32'd1);
        check("xor_carry", {31'd0, res_carry}, 32'd0);
        tick();
`endif

        // Counter wrap: 255 accepts reach 255, one more wraps to 0.
        do_reset();
        res_ready = 1'b1;
        for (int i = 0; i < 255; i++) begin
            set_req(i % 2, 1'b1, 3'(i % 8), 4'(i), 4'(i / 16));
            set_req((i + 1) % 2, 1'b0, 3'd0, 4'd0, 4'd0);
            tick();
        end
        set_req(0, 1'b0, 3'd0, 4'd0, 4'd0);
        set_req(1, 1'b0, 3'd0, 4'd0, 4'd0);
        @(negedge clk);
        check("count_255", {24'd0, op_count}, 32'd255);
        set_req(1, 1'b1, 3'd0, 4'd15, 4'd15);
        tick();
        set_req(1, 1'b0, 3'd0, 4'd0, 4'd0);
        @(negedge clk);
        check("count_wrap", {24'd0, op_count}, 32'd0);
        check("wrap_data", {28'd0, res_data}, 32'd14);
        check("wrap_carry", {31'd0, res_carry}, 32'd1);
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_alu4_arbiter
